// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO pair for MFHI/MFLO/MTHI/MTLO.
// Latency 33 edges from start to done; start and moves are ignored while busy, and there is no stall input.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, acc_hi, acc_lo, hi_q, lo_q;
    logic [4:0]  cnt;

    logic        accept;
    logic        is_div, a_neg, b_neg, in_neg;
    logic [31:0] b_mag, in_a_mag;
    logic [32:0] mul_sum, div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] res_hi, res_lo;

    assign accept   = start && (state == IDLE || state == DONE);
    assign is_div   = op_q[1];
    assign a_neg    = ~op_q[0] & a_q[31];
    assign b_neg    = ~op_q[0] & b_q[31];
    assign b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    assign in_neg   = ~op[0] & src_a[31];
    assign in_a_mag = in_neg ? (32'd0 - src_a) : src_a;

    // Multiply: acc_lo holds the remaining multiplier bits, shifted out as product bits arrive.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
    assign div_ge    = ~div_diff[33];

    assign prod_fix = (a_neg ^ b_neg) ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};

    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (is_div) begin
            if (b_q == 32'd0) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = (a_neg ^ b_neg) ? (32'd0 - acc_lo) : acc_lo;
                res_hi = a_neg ? (32'd0 - acc_hi) : acc_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            cnt    <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (accept) begin
            op_q   <= op;
            a_q    <= src_a;
            b_q    <= src_b;
            acc_hi <= 32'd0;
            acc_lo <= in_a_mag;
            cnt    <= 5'd0;
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            if (is_div) begin
                acc_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                acc_lo <= {acc_lo[30:0], div_ge};
            end else begin
                acc_hi <= mul_sum[32:1];
                acc_lo <= {mul_sum[0], acc_lo[31:1]};
            end
        end else if (state == FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: result values, 33-edge latency, busy/hold behaviour and corner sequences.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        mv;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one operation (from IDLE or DONE) and waits for done; returns in the DONE cycle.
    task automatic run(input vec_t v, input int idx);
        logic [31:0] h0, l0;
        int lat, busy_bad, stable_bad;
        h0 = hi; l0 = lo;
        lat = 0; busy_bad = 0; stable_bad = 0;
        start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
        if (v.mv) begin
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        step();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            step();
            if (done) lat = n;
            else begin
                if (!busy) busy_bad++;
                if (hi !== h0 || lo !== l0) stable_bad++;
            end
        end
        chk($sformatf("vec%0d latency", idx), 64'(lat), 64'd33);
        chk($sformatf("vec%0d hi", idx), 64'(hi), 64'(v.hi));
        chk($sformatf("vec%0d lo", idx), 64'(lo), 64'(v.lo));
        chk($sformatf("vec%0d busy gaps", idx), 64'(busy_bad), 64'd0);
        chk($sformatf("vec%0d hi/lo held", idx), 64'(stable_bad), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int dcnt, lat;
        logic [31:0] rh, rl;

        vecs.push_back('{MULTU, 32'hFFFF_FFFF, 32'h2,          1'b0, 32'h1,          32'hFFFF_FFFE});
        vecs.push_back('{MULT,  32'hFFFF_FFFD, 32'h7,          1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFEB});
        vecs.push_back('{DIV,   32'hFFFF_FFF9, 32'h2,          1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFD});
        vecs.push_back('{DIVU,  32'h7,         32'h0,          1'b0, 32'h7,          32'hFFFF_FFFF});
        vecs.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0,          32'h8000_0000});
        vecs.push_back('{DIV,   32'hFFFF_FFF9, 32'h0,          1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFF});
        vecs.push_back('{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'h0,          32'h1});
        vecs.push_back('{DIV,   32'h7,         32'hFFFF_FFFE,  1'b0, 32'h1,          32'hFFFF_FFFD});
        vecs.push_back('{MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF,  1'b0, 32'h3FFF_FFFF,  32'h1});
        vecs.push_back('{DIVU,  32'd100,       32'd7,          1'b0, 32'd2,          32'd14});
        vecs.push_back('{DIVU,  32'hFFFF_FFFF, 32'h1,          1'b0, 32'h0,          32'hFFFF_FFFF});
        vecs.push_back('{MULT,  32'h8000_0000, 32'h2,          1'b0, 32'hFFFF_FFFF,  32'h0});

        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        step();

        // Moves in IDLE take effect after one edge.
        mthi = 1'b1; wdata = 32'hA5A5_A5A5;
        step();
        mthi = 1'b0;
        chk("mthi idle hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi idle lo", 64'(lo), 64'd0);
        mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
        step();
        mtlo = 1'b0;
        chk("mtlo idle lo", 64'(lo), 64'h5A5A_5A5A);

        // start wins over a simultaneous move: hi/lo must hold until the result.
        run('{MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12}, 99);

        // Back-to-back: each vector is started in the DONE cycle of the previous one.
        foreach (vecs[i]) run(vecs[i], i);

        // start and mthi during CALC are ignored; one done pulse with the first result.
        step();
        start = 1'b1; op = MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'h2;
        step();
        start = 1'b0;
        dcnt = 0; lat = 0; rh = '0; rl = '0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) begin
                start = 1'b1; op = DIVU; src_a = 32'h7; src_b = 32'h0;
                mthi = 1'b1; wdata = 32'hA5A5_A5A5;
            end
            step();
            start = 1'b0; mthi = 1'b0;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat = n; rh = hi; rl = lo;
                end
            end
        end
        chk("busy start latency", 64'(lat), 64'd33);
        chk("busy start hi", 64'(rh), 64'h1);
        chk("busy start lo", 64'(rl), 64'hFFFF_FFFE);
        chk("busy start done count", 64'(dcnt), 64'd1);
        chk("idle after done", 64'(busy | done), 64'd0);

        // Reset at counter 10 aborts the operation with no done pulse.
        start = 1'b1; op = MULT; src_a = 32'hFFFF_FFFD; src_b = 32'h7;
        step();
        start = 1'b0;
        for (int n = 0; n < 10; n++) step();
        chk("pre-abort busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort no done", 64'(dcnt), 64'd0);
        chk("abort lo held", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
